// File: rtl/key_search_controller.sv
// key_search_controller: sequences a key generator and a decrypt core to
// search for a key that yields valid plaintext. Each key is requested from
// the generator, then handed to the decrypt core. The search ends when a key
// decrypts validly (FOUND), when the generator's final key fails or the
// generator stops answering (FAILED), or when the caller aborts.
`timescale 1ns/1ps
module key_search_controller #(
  parameter int GEN_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        abort,
  output logic        gen_start,
  input  logic        gen_finished,
  input  logic        gen_terminated,
  input  logic [23:0] gen_key,
  output logic        dec_start,
  output logic [23:0] dec_key,
  input  logic        dec_done,
  input  logic        dec_valid,
  output logic        busy,
  output logic        found,
  output logic        failed,
  output logic        timeout,
  output logic [23:0] found_key,
  output logic [23:0] attempts
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_WAIT_GEN = 3'd2,
    S_LAUNCH   = 3'd3,
    S_WAIT_DEC = 3'd4,
    S_FOUND    = 3'd5,
    S_FAILED   = 3'd6
  } state_t;

  // Last counter value still spent waiting; reaching it without a pulse
  // means GEN_TIMEOUT cycles have gone by in WAIT_GEN.
  localparam logic [7:0]  GEN_CNT_LAST = 8'(GEN_TIMEOUT - 1);
  localparam logic [23:0] ATTEMPTS_MAX = 24'hFFFFFF;

  state_t      state_q, state_d;
  logic [23:0] dec_key_q, dec_key_d;
  logic [23:0] found_key_q, found_key_d;
  logic [23:0] attempts_q, attempts_d;
  logic        last_q, last_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  gen_cnt_q, gen_cnt_d;

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dec_key_q   <= 24'd0;
      found_key_q <= 24'd0;
      attempts_q  <= 24'd0;
      last_q      <= 1'b0;
      timeout_q   <= 1'b0;
      gen_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      dec_key_q   <= dec_key_d;
      found_key_q <= found_key_d;
      attempts_q  <= attempts_d;
      last_q      <= last_d;
      timeout_q   <= timeout_d;
      gen_cnt_q   <= gen_cnt_d;
    end
  end

  // Next-state and datapath update; abort overrides every state.
  always_comb begin
    state_d     = state_q;
    dec_key_d   = dec_key_q;
    found_key_d = found_key_q;
    attempts_d  = attempts_q;
    last_d      = last_q;
    timeout_d   = timeout_q;
    gen_cnt_d   = gen_cnt_q;

    if (abort) begin
      state_d   = S_IDLE;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FOUND, S_FAILED: begin
          if (go) begin
            state_d     = S_REQ;
            timeout_d   = 1'b0;
            attempts_d  = 24'd0;
            found_key_d = 24'd0;
          end else begin
            state_d = state_q;
          end
        end
        S_REQ: begin
          // Counter is zeroed here so it reads 0 on the first WAIT_GEN cycle.
          gen_cnt_d = 8'd0;
          state_d   = S_WAIT_GEN;
        end
        S_WAIT_GEN: begin
          if (gen_finished || gen_terminated) begin
            // A simultaneous finished+terminated counts as the final key.
            dec_key_d = gen_key;
            last_d    = gen_terminated;
            state_d   = S_LAUNCH;
          end else if (gen_cnt_q == GEN_CNT_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_FAILED;
          end else begin
            gen_cnt_d = gen_cnt_q + 8'd1;
          end
        end
        S_LAUNCH: begin
          if (attempts_q != ATTEMPTS_MAX) begin
            attempts_d = attempts_q + 24'd1;
          end else begin
            attempts_d = attempts_q;
          end
          state_d = S_WAIT_DEC;
        end
        S_WAIT_DEC: begin
          if (dec_done && dec_valid) begin
            found_key_d = dec_key_q;
            state_d     = S_FOUND;
          end else if (dec_done && last_q) begin
            timeout_d = 1'b0;
            state_d   = S_FAILED;
          end else if (dec_done) begin
            state_d = S_REQ;
          end else begin
            state_d = S_WAIT_DEC;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the state register or driven straight from flops.
  always_comb begin
    gen_start = 1'b0;
    dec_start = 1'b0;
    busy      = 1'b0;
    found     = 1'b0;
    failed    = 1'b0;
    case (state_q)
      S_REQ:      begin gen_start = 1'b1; busy = 1'b1; end
      S_WAIT_GEN: begin busy = 1'b1; end
      S_LAUNCH:   begin dec_start = 1'b1; busy = 1'b1; end
      S_WAIT_DEC: begin busy = 1'b1; end
      S_FOUND:    begin found = 1'b1; end
      S_FAILED:   begin failed = 1'b1; end
      default:    begin busy = 1'b0; end
    endcase
    dec_key   = dec_key_q;
    found_key = found_key_q;
    attempts  = attempts_q;
    timeout   = timeout_q;
  end

endmodule

// File: tb/tb_key_search_controller.sv
// Bench for key_search_controller: behavioural generator and decrypt-core
// models, directed searches, and a scoreboard that checks every completion.
`timescale 1ns/1ps
module tb_key_search_controller;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset, go, abort;
  logic        gen_start, gen_finished, gen_terminated;
  logic [23:0] gen_key;
  logic        dec_start, dec_done, dec_valid;
  logic        dec_done_m, dec_valid_m, spur_done;
  logic [23:0] dec_key, found_key, attempts;
  logic        busy, found, failed, timeout;

  assign dec_done  = dec_done_m | spur_done;
  assign dec_valid = spur_done ? 1'b1 : dec_valid_m;

  key_search_controller #(.GEN_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .go(go), .abort(abort),
    .gen_start(gen_start), .gen_finished(gen_finished),
    .gen_terminated(gen_terminated), .gen_key(gen_key),
    .dec_start(dec_start), .dec_key(dec_key), .dec_done(dec_done),
    .dec_valid(dec_valid), .busy(busy), .found(found), .failed(failed),
    .timeout(timeout), .found_key(found_key), .attempts(attempts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        f;
    logic        fl;
    logic        to;
    logic [23:0] key;
    logic [23:0] att;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // model configuration
  int          gen_delay = 1;
  bit          silent = 1'b0;
  bit          spurious = 1'b0;
  bit          use_both = 1'b0;
  logic [23:0] both_key = 24'hFFFFFF;
  logic [23:0] term_key = 24'hFFFFFF;
  logic [23:0] next_key = 24'd0;
  int          dec_delay = 2;
  logic [23:0] valid_key = 24'd0;
  bit          never_valid = 1'b0;
  int          n_gen_start = 0;
  int          n_dec_start = 0;
  logic [23:0] last_tested = 24'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // generator model: answers each gen_start after gen_delay cycles
  initial begin
    gen_finished = 1'b0; gen_terminated = 1'b0; gen_key = 24'd0; spur_done = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_start === 1'b1) begin
        n_gen_start++;
        if (!silent) begin
          for (int k = 0; k < gen_delay; k++) begin
            @(negedge clk);
            spur_done = spurious && (k == 0);
          end
          gen_key = next_key;
          if (use_both && next_key == both_key) begin
            gen_finished = 1'b1; gen_terminated = 1'b1;
          end else if (next_key == term_key) begin
            gen_terminated = 1'b1;
          end else begin
            gen_finished = 1'b1;
          end
          next_key = next_key + 24'd1;
          @(negedge clk);
          gen_finished = 1'b0; gen_terminated = 1'b0; spur_done = 1'b0;
        end
      end
    end
  end

  // decrypt-core model: completes dec_delay cycles after dec_start
  initial begin
    logic [23:0] k;
    dec_done_m = 1'b0; dec_valid_m = 1'b0;
    forever begin
      @(negedge clk);
      if (dec_start === 1'b1) begin
        n_dec_start++;
        k = dec_key;
        repeat (dec_delay) @(negedge clk);
        if (busy) chk("dec_key_stable", {8'd0, dec_key}, {8'd0, k});
        last_tested = k;
        dec_done_m  = 1'b1;
        dec_valid_m = !never_valid && (k == valid_key);
        @(negedge clk);
        dec_done_m = 1'b0; dec_valid_m = 1'b0;
      end
    end
  end

  // monitor: each rising completion flag pops one expected result
  initial begin
    logic done_prev, done_now;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      done_now = found | failed;
      if (done_now && !done_prev) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_completion found=%0b failed=%0b expected=none", found, failed);
        end else begin
          e = exp_q.pop_front();
          chk("found",     {31'd0, found},     {31'd0, e.f});
          chk("failed",    {31'd0, failed},    {31'd0, e.fl});
          chk("timeout",   {31'd0, timeout},   {31'd0, e.to});
          chk("found_key", {8'd0, found_key},  {8'd0, e.key});
          chk("attempts",  {8'd0, attempts},   {8'd0, e.att});
        end
      end
      done_prev = done_now;
    end
  end

  task automatic push(input logic f, input logic fl, input logic to,
                      input logic [23:0] key, input logic [23:0] att);
    exp_t e;
    e.f = f; e.fl = fl; e.to = to; e.key = key; e.att = att;
    exp_q.push_back(e);
  endtask

  task automatic start_search(input int hold);
    go = 1'b1;
    repeat (hold) @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!(found | failed) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!(found | failed)) chk({nm, "_completion_wait"}, 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_dec_start();
    int n = 0;
    while (n_dec_start == 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n_dec_start == 0) chk("dec_start_wait", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; go = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_found",     {31'd0, found},     32'd0);
    chk("rst_failed",    {31'd0, failed},    32'd0);
    chk("rst_timeout",   {31'd0, timeout},   32'd0);
    chk("rst_gen_start", {31'd0, gen_start}, 32'd0);
    chk("rst_dec_start", {31'd0, dec_start}, 32'd0);
    chk("rst_dec_key",   {8'd0, dec_key},    32'd0);
    chk("rst_found_key", {8'd0, found_key},  32'd0);
    chk("rst_attempts",  {8'd0, attempts},   32'd0);
    @(negedge clk);

    // T1: keys 0,1,2,3; key 3 decrypts -> found after 4 attempts
    next_key = 24'd0; valid_key = 24'd3; n_gen_start = 0;
    push(1'b1, 1'b0, 1'b0, 24'd3, 24'd4);
    start_search(1);
    wait_done("t1");
    chk("t1_gen_starts", n_gen_start, 32'd4);

    // T2: generator ends at 0xF, nothing decrypts -> 16 attempts, failed
    next_key = 24'd0; term_key = 24'h00000F; never_valid = 1'b1;
    n_gen_start = 0; n_dec_start = 0;
    push(1'b0, 1'b1, 1'b0, 24'd0, 24'd16);
    start_search(1);
    wait_done("t2");
    chk("t2_last_tested", {8'd0, last_tested}, 32'h0000000F);
    chk("t2_gen_starts", n_gen_start, 32'd16);
    chk("t2_dec_starts", n_dec_start, 32'd16);

    // T3: silent generator -> timeout exactly TO cycles after WAIT_GEN entry
    silent = 1'b1; term_key = 24'hFFFFFF; n_dec_start = 0;
    push(1'b0, 1'b1, 1'b1, 24'd0, 24'd0);
    start_search(1);
    // now in REQ; WAIT_GEN starts next cycle and lasts TO cycles
    cyc = 0;
    while (!failed && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("t3_timeout_cycles", cyc, TO + 1);
    repeat (2) @(negedge clk);
    chk("t3_dec_starts", n_dec_start, 32'd0);

    // T4: abort in WAIT_DEC; the late (valid) dec_done must be ignored
    silent = 1'b0; never_valid = 1'b0; next_key = 24'd0; valid_key = 24'd0;
    dec_delay = 10; n_dec_start = 0;
    start_search(1);
    wait_dec_start();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_abort_busy",    {31'd0, busy},    32'd0);
    chk("t4_abort_found",   {31'd0, found},   32'd0);
    chk("t4_abort_failed",  {31'd0, failed},  32'd0);
    chk("t4_abort_timeout", {31'd0, timeout}, 32'd0);
    repeat (15) @(negedge clk);
    chk("t4_late_done_found", {31'd0, found}, 32'd0);
    chk("t4_late_done_busy",  {31'd0, busy},  32'd0);
    dec_delay = 2; next_key = 24'd0;
    push(1'b1, 1'b0, 1'b0, 24'd0, 24'd1);
    start_search(1);
    chk("t4_restart_attempts", {8'd0, attempts}, 32'd0);
    wait_done("t4");

    // T5: finished+terminated together on key 7, spurious dec_done in
    // WAIT_GEN, go held for 20 busy cycles -> failed after 8 attempts
    next_key = 24'd0; never_valid = 1'b1; use_both = 1'b1; both_key = 24'd7;
    spurious = 1'b1; gen_delay = 3; n_gen_start = 0;
    push(1'b0, 1'b1, 1'b0, 24'd0, 24'd8);
    start_search(20);
    wait_done("t5");
    chk("t5_gen_starts", n_gen_start, 32'd8);
    chk("t5_last_tested", {8'd0, last_tested}, 32'd7);

    // T6: reset mid-search -> no further strobes, everything cleared
    use_both = 1'b0; spurious = 1'b0; gen_delay = 1; dec_delay = 10;
    next_key = 24'd0; n_dec_start = 0;
    start_search(1);
    wait_dec_start();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_gen_start = 0; n_dec_start = 0;
    repeat (30) @(negedge clk);
    chk("t6_gen_starts", n_gen_start, 32'd0);
    chk("t6_dec_starts", n_dec_start, 32'd0);
    chk("t6_busy",       {31'd0, busy},     32'd0);
    chk("t6_attempts",   {8'd0, attempts},  32'd0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
